// File: rtl/serial_pkg.sv
// Shared constants for the bit serializer: FSM state encodings and default word width.
package serial_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

endpackage

// File: rtl/serial_bit_serializer.sv
// Parallel-to-serial converter with a one-word holding register so back-to-back words
// stream with no idle cycle between them.
//
// state | meaning
// IDLE  | nothing shifting; si and bit_valid held low
// SHIFT | one bit of the current word on si per cycle
module serial_bit_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             si,
  output logic             bit_valid,
  output logic             last_bit,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             si_q, si_d;
  logic             bit_valid_q, bit_valid_d;
  logic             last_bit_q, last_bit_d;
  logic             accept;
  logic             at_last;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  always_comb begin
    accept      = load_valid & ~hold_full_q;
    at_last     = (cnt_q == CNT_LAST);
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d = load_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      default: begin
        if (at_last) begin
          // Held word wins over a fresh offer; load_ready is low then, so no offer can land.
          cnt_d = '0;
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
          end else if (accept) begin
            shift_d = load_data;
          end else begin
            state_d = IDLE;
          end
        end else begin
          shift_d = advance(shift_q);
          cnt_d   = cnt_q + CW'(1);
          if (accept) begin
            hold_d      = load_data;
            hold_full_d = 1'b1;
          end
        end
      end
    endcase

    // Outputs are registered from next-state values so the first bit appears one cycle after accept.
    bit_valid_d = (state_d == SHIFT);
    si_d        = bit_valid_d & head_bit(shift_d);
    last_bit_d  = bit_valid_d & (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      si_q        <= 1'b0;
      bit_valid_q <= 1'b0;
      last_bit_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      si_q        <= si_d;
      bit_valid_q <= bit_valid_d;
      last_bit_q  <= last_bit_d;
    end
  end

  assign load_ready = ~hold_full_q;
  assign busy       = (state_q == SHIFT) | hold_full_q;
  assign si         = si_q;
  assign bit_valid  = bit_valid_q;
  assign last_bit   = last_bit_q;

endmodule

// File: tb/tb_serial_bit_serializer.sv
// Self-checking bench: MSB-first and LSB-first instances, scoreboard of expected {last_bit, si}.
module tb_serial_bit_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] load_data = 8'h00, load_data_l = 8'h00;
  logic       load_valid = 1'b0, load_valid_l = 1'b0;
  logic       load_ready, si, bit_valid, last_bit, busy;
  logic       load_ready_l, si_l, bit_valid_l, last_bit_l, busy_l;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp_l_q[$];

  always #5 clk = ~clk;

  serial_bit_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut (
    .clk(clk), .rst_n(rst_n), .load_data(load_data), .load_valid(load_valid),
    .load_ready(load_ready), .si(si), .bit_valid(bit_valid), .last_bit(last_bit), .busy(busy)
  );

  serial_bit_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst_n(rst_n), .load_data(load_data_l), .load_valid(load_valid_l),
    .load_ready(load_ready_l), .si(si_l), .bit_valid(bit_valid_l), .last_bit(last_bit_l), .busy(busy_l)
  );

  // Scoreboard push: every handshake queues the word's bits in transmit order.
  always @(posedge clk) begin
    if (rst_n && load_valid && load_ready) begin
      hs_cnt++;
      for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), load_data[7-i]});
    end
    if (rst_n && load_valid_l && load_ready_l) begin
      for (int i = 0; i < 8; i++) exp_l_q.push_back({(i == 7), load_data_l[i]});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({si, bit_valid, last_bit, busy, load_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_msb: got si/bv/last/busy/rdy=%b want 00001",
               {si, bit_valid, last_bit, busy, load_ready});
    end
    checks++;
    if ({si_l, bit_valid_l, last_bit_l, busy_l, load_ready_l} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_lsb: got si/bv/last/busy/rdy=%b want 00001",
               {si_l, bit_valid_l, last_bit_l, busy_l, load_ready_l});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bit_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_release_idle: got bv/busy=%b want 00", {bit_valid, busy});
    end
  endtask

  task automatic test_single();
    logic [7:0] w = 8'hB1;
    logic [1:0] e;
    load_data = w;
    load_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k <= 8) begin
        checks++;
        if ({bit_valid, si, last_bit} !== {1'b1, w[8-k], (k == 8)}) begin
          errors++;
          $display("FAIL single_b1 cycle%0d: got bv/si/last=%b want %b", k,
                   {bit_valid, si, last_bit}, {1'b1, w[8-k], (k == 8)});
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL single_b1_sb cycle%0d: got empty scoreboard want one bit", k);
        end else begin
          e = exp_q.pop_front();
          if ({last_bit, si} !== e) begin
            errors++;
            $display("FAIL single_b1_sb cycle%0d: got last/si=%b want %b", k, {last_bit, si}, e);
          end
        end
      end else begin
        checks++;
        if ({bit_valid, si, busy} !== 3'b000) begin
          errors++;
          $display("FAIL single_b1_idle: got bv/si/busy=%b want 000", {bit_valid, si, busy});
        end
      end
      if (k == 1) load_valid = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] e;
    logic [15:0] stream = 16'hA53C;
    load_data = 8'hA5;
    load_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k <= 16) begin
        checks++;
        if ({bit_valid, busy, si} !== {2'b11, stream[16-k]}) begin
          errors++;
          $display("FAIL b2b_bit cycle%0d: got bv/busy/si=%b want %b", k,
                   {bit_valid, busy, si}, {2'b11, stream[16-k]});
        end
        checks++;
        if (load_ready !== !(k >= 2 && k <= 8)) begin
          errors++;
          $display("FAIL b2b_ready cycle%0d: got %b want %b", k, load_ready, !(k >= 2 && k <= 8));
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_sb cycle%0d: got empty scoreboard want one bit", k);
        end else begin
          e = exp_q.pop_front();
          if ({last_bit, si} !== e) begin
            errors++;
            $display("FAIL b2b_sb cycle%0d: got last/si=%b want %b", k, {last_bit, si}, e);
          end
        end
      end else begin
        checks++;
        if ({bit_valid, si, busy} !== 3'b000) begin
          errors++;
          $display("FAIL b2b_idle: got bv/si/busy=%b want 000", {bit_valid, si, busy});
        end
      end
      if (k == 1) load_data = 8'h3C;
      if (k == 2) load_valid = 1'b0;
    end
  endtask

  task automatic test_continuous();
    logic [7:0] words [3];
    logic [1:0] e;
    int idx = 0;
    int hs0 = hs_cnt;
    logic rdy_prev;
    words[0] = 8'hFF; words[1] = 8'h00; words[2] = 8'hFF;
    load_data = words[0];
    load_valid = 1'b1;
    rdy_prev = load_ready;
    @(posedge clk);
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k <= 24) begin
        checks++;
        if ({bit_valid, busy, si} !== {2'b11, (k <= 8 || k >= 17)}) begin
          errors++;
          $display("FAIL cont_bit cycle%0d: got bv/busy/si=%b want %b", k,
                   {bit_valid, busy, si}, {2'b11, (k <= 8 || k >= 17)});
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL cont_sb cycle%0d: got empty scoreboard want one bit", k);
        end else begin
          e = exp_q.pop_front();
          if ({last_bit, si} !== e) begin
            errors++;
            $display("FAIL cont_sb cycle%0d: got last/si=%b want %b", k, {last_bit, si}, e);
          end
        end
      end else begin
        checks++;
        if ({bit_valid, busy} !== 2'b00) begin
          errors++;
          $display("FAIL cont_idle: got bv/busy=%b want 00", {bit_valid, busy});
        end
      end
      if (load_valid && rdy_prev) begin
        idx++;
        if (idx == 3) load_valid = 1'b0;
        else load_data = words[idx];
      end
      rdy_prev = load_ready;
    end
    checks++;
    if (hs_cnt - hs0 !== 3) begin
      errors++;
      $display("FAIL cont_handshakes: got %0d want 3", hs_cnt - hs0);
    end
  endtask

  task automatic test_lsb();
    logic [1:0] e;
    load_data_l = 8'h01;
    load_valid_l = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k <= 8) begin
        checks++;
        if ({bit_valid_l, si_l, last_bit_l} !== {1'b1, (k == 1), (k == 8)}) begin
          errors++;
          $display("FAIL lsb_01 cycle%0d: got bv/si/last=%b want %b", k,
                   {bit_valid_l, si_l, last_bit_l}, {1'b1, (k == 1), (k == 8)});
        end
        checks++;
        if (exp_l_q.size() == 0) begin
          errors++;
          $display("FAIL lsb_sb cycle%0d: got empty scoreboard want one bit", k);
        end else begin
          e = exp_l_q.pop_front();
          if ({last_bit_l, si_l} !== e) begin
            errors++;
            $display("FAIL lsb_sb cycle%0d: got last/si=%b want %b", k, {last_bit_l, si_l}, e);
          end
        end
      end else begin
        checks++;
        if ({bit_valid_l, si_l, busy_l} !== 3'b000) begin
          errors++;
          $display("FAIL lsb_idle: got bv/si/busy=%b want 000", {bit_valid_l, si_l, busy_l});
        end
      end
      if (k == 1) load_valid_l = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] e;
    load_data = 8'hF0;
    load_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if ({bit_valid, si} !== 2'b11) begin
        errors++;
        $display("FAIL rstmid_bit cycle%0d: got bv/si=%b want 11", k, {bit_valid, si});
      end
      if (k == 1) load_data = 8'h55;
      if (k == 2) load_valid = 1'b0;
    end
    checks++;
    if ({busy, load_ready} !== 2'b10) begin
      errors++;
      $display("FAIL rstmid_held: got busy/rdy=%b want 10", {busy, load_ready});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({si, bit_valid, last_bit, busy, load_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL rstmid_async: got si/bv/last/busy/rdy=%b want 00001",
               {si, bit_valid, last_bit, busy, load_ready});
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if ({bit_valid, si, busy} !== 3'b000) begin
        errors++;
        $display("FAIL rstmid_quiet cycle%0d: got bv/si/busy=%b want 000", k, {bit_valid, si, busy});
      end
    end
  endtask

  task automatic test_last_edge(input logic hold_busy);
    logic [1:0] e;
    logic [15:0] stream;
    int hs0 = hs_cnt;
    stream = hold_busy ? 16'hC33C : 16'h965A;
    load_data = stream[15:8];
    load_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k <= 16) begin
        checks++;
        if ({bit_valid, si} !== {1'b1, stream[16-k]}) begin
          errors++;
          $display("FAIL lastedge%0d_bit cycle%0d: got bv/si=%b want %b", hold_busy, k,
                   {bit_valid, si}, {1'b1, stream[16-k]});
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL lastedge%0d_sb cycle%0d: got empty scoreboard want one bit", hold_busy, k);
        end else begin
          e = exp_q.pop_front();
          if ({last_bit, si} !== e) begin
            errors++;
            $display("FAIL lastedge%0d_sb cycle%0d: got last/si=%b want %b", hold_busy, k,
                     {last_bit, si}, e);
          end
        end
      end else begin
        checks++;
        if ({bit_valid, si, busy} !== 3'b000) begin
          errors++;
          $display("FAIL lastedge%0d_idle: got bv/si/busy=%b want 000", hold_busy, {bit_valid, si, busy});
        end
      end
      if (k == 8) begin
        checks++;
        if ({last_bit, load_ready} !== {1'b1, !hold_busy}) begin
          errors++;
          $display("FAIL lastedge%0d_ready: got last/rdy=%b want %b", hold_busy,
                   {last_bit, load_ready}, {1'b1, !hold_busy});
        end
      end
      if (hold_busy) begin
        if (k == 1) load_data = stream[7:0];
        if (k == 2) load_valid = 1'b0;
        if (k == 8) begin load_data = 8'hE7; load_valid = 1'b1; end
        if (k == 9) load_valid = 1'b0;
      end else begin
        if (k == 1) load_valid = 1'b0;
        if (k == 8) begin load_data = stream[7:0]; load_valid = 1'b1; end
        if (k == 9) load_valid = 1'b0;
      end
    end
    checks++;
    if (hs_cnt - hs0 !== 2) begin
      errors++;
      $display("FAIL lastedge%0d_handshakes: got %0d want 2", hold_busy, hs_cnt - hs0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_continuous();
    test_lsb();
    test_last_edge(1'b0);
    test_last_edge(1'b1);
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover bits want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_bit_serializer.md
SERIAL_BIT_SERIALIZER -- requirements
Module: serial_bit_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning bits per word (legal range 2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning 1 = shift MSB first and 0 = shift LSB first.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port load_data, input, WIDTH bits: parallel word to serialize.
REQ-006 SHALL have port load_valid, input, 1 bit: load_data is valid.
REQ-007 SHALL have port load_ready, output, 1 bit: block can accept a word this cycle.
REQ-008 SHALL have port si, output, 1 bit: serial bit stream driving the downstream sequence detector input.
REQ-009 SHALL have port bit_valid, output, 1 bit: si carries a data bit this cycle.
REQ-010 SHALL have port last_bit, output, 1 bit: current si bit is the final bit of a word.
REQ-011 SHALL have port busy, output, 1 bit: a word is shifting or one is held.

Function
REQ-012 SHALL register si, bit_valid and last_bit (no combinational path from inputs).
REQ-013 SHALL transfer a word only when load_valid and load_ready are both high at a rising edge.
REQ-014 SHALL drive load_ready = NOT hold_full, where hold_full is the one-entry holding register flag.
REQ-015 SHALL use two states, IDLE and SHIFT.
REQ-016 SHALL, when a word is accepted in IDLE, load it directly into the shift register and enter SHIFT; first bit on si in the cycle after the accepting edge (latency 1).
REQ-017 SHALL, when a word is accepted in SHIFT, place it in the holding register.
REQ-018 SHALL emit exactly one bit per cycle in SHIFT; bit counter 0..WIDTH-1, width $clog2(WIDTH).
REQ-019 SHALL assert last_bit only while bit counter = WIDTH-1.
REQ-020 SHALL, at the edge ending the last bit, select the next word by priority:
  - hold_full: move the holding word into the shift register, clear hold_full, stay in SHIFT, no gap.
  - else, accept this edge: load the input word directly, stay in SHIFT, no gap.
  - else: go to IDLE.
REQ-021 SHALL hold si=0 and bit_valid=0 in IDLE.
REQ-022 SHALL drive busy = (state==SHIFT) OR hold_full.
REQ-023 SHALL leave held data unchanged while load_ready=0, regardless of load_valid.

Reset
REQ-024 SHALL, on rst_n low, immediately force si=0, bit_valid=0, last_bit=0, busy=0, load_ready=1, state=IDLE, counter=0, hold_full=0.
REQ-025 SHALL discard any partially shifted or held word on reset mid-operation; no bits are emitted after release until a new accept.
REQ-026 SHALL resume normal operation at the first rising edge after rst_n deasserts.

Structure
REQ-027 SHALL take the state enum (IDLE, SHIFT) and the DEFAULT_WIDTH constant from shared package serial_pkg.
REQ-028 SHALL be a single module with no sub-modules; the counter, shift register and holding register are inline.

Verification
REQ-029 WIDTH=8, MSB_FIRST=1, load 8'hB1 from IDLE -> si = 1,0,1,1,0,0,0,1 over cycles 1..8, bit_valid high for those 8 cycles, last_bit only in cycle 8, then IDLE with si=0.
REQ-030 Load 8'hA5, then 8'h3C one cycle later -> 16 contiguous bits 10100101 00111100 with no gap; load_ready low from the second accept until the hold-to-shift transfer.
REQ-031 MSB_FIRST=0, load 8'h01 -> si = 1 then seven 0s.
REQ-032 Load valid held continuously with words 8'hFF, 8'h00, 8'hFF -> 24 bits back-to-back; busy stays high throughout; exactly 3 handshakes.
REQ-033 Assert rst_n low after 3 bits of 8'hF0 while a held word is pending -> si, bit_valid and busy go 0 asynchronously; load_ready=1; no further bits after release.
REQ-034 Offer a word at the exact last-bit edge with hold empty -> direct load with zero-cycle gap; offer it with hold full -> load_ready=0 and the word is not accepted.
